float_to_int: RTL and testbench
===============================

Name: float_to_int

Overview:
Converts an IEEE-754 single-precision value to a signed 32-bit two's-complement integer. It is the reverse-direction companion to the team's integer-to-float converter. It uses a strobe/acknowledge handshake on both sides and a fixed multi-cycle state machine. It sits on the datapath between floating-point producers and integer consumers; flag outputs feed the status/exception logic.

Parameters:
NAN_VALUE, 32'h8000_0000, integer result returned for any NaN input.
POS_SAT, 32'h7FFF_FFFF, result for positive overflow and +Inf.
NEG_SAT, 32'h8000_0000, result for negative overflow and -Inf.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
input_a  input  32  IEEE-754 single operand
input_a_stb  input  1  operand valid
input_a_ack  output  1  converter ready to accept operand
output_z  output  32  signed integer result
output_z_stb  output  1  result valid
output_z_ack  input  1  consumer accepts result
flag_invalid  output  1  input was NaN (valid with output_z_stb)
flag_overflow  output  1  magnitude not representable / Inf (valid with output_z_stb)
flag_inexact  output  1  fractional bits discarded (valid with output_z_stb)

Behaviour:
- Reset (rst=0, async): state IDLE, input_a_ack=1, output_z_stb=0, output_z=0, all flags 0. An in-flight operation is dropped and nothing is emitted.
- States: IDLE -> UNPACK -> ALIGN -> ROUND -> DONE -> IDLE.
- IDLE: input_a_ack=1. On input_a_stb=1 at a clock edge, register input_a and move to UNPACK.
- UNPACK: split sign s, exponent E[7:0], fraction F[22:0]; compute e = E-127 as a signed 9-bit value. Classify:
  - E=255 with F!=0: NaN.
  - E=255 with F=0: Inf.
  - E=0: zero or denormal.
- ALIGN: form M = {1,F} (24 bits).
  - e >= 23: magnitude = M << (e-23).
  - 0 <= e < 23: magnitude = M >> (23-e); keep guard bit and sticky OR of the bits shifted out.
  - e < 0, or E=0: magnitude = 0; inexact = (input nonzero).
- ROUND: apply the rounding mode (Optional Feature), then the special cases:
  - NaN -> NAN_VALUE, invalid=1.
  - Inf -> POS_SAT/NEG_SAT by sign, overflow=1.
  - e >= 31 -> saturate by sign with overflow=1. Exception: input exactly 32'hCF00_0000 (-2^31) -> 32'h8000_0000, overflow=0.
  - Otherwise negate the magnitude when s=1.
  - -0.0 gives 0.
- DONE: output_z_stb=1; output_z and flags are held stable. On output_z_ack=1 -> IDLE. Any number of ack-low cycles is a stall; input_a_ack stays 0 throughout the stall.
- Latency: with the acceptance edge counted as edge 0, output_z_stb is high after edge 3. Minimum initiation interval is 5 cycles; input_a_ack returns on the cycle after the ack edge.
- input_a_stb outside IDLE is ignored; input_a is sampled only at the acceptance edge.
- inexact is never set together with invalid. For saturating cases, inexact=0.

Optional Feature:
ROUND_NEAREST_EN
- Defined: round to nearest, ties-to-even, using guard and sticky.
  - e = -1 is handled as guard=1, sticky=(F!=0), so 0.5 -> 0 and 0.75 -> 1.
  - Round-up cannot overflow, because any fractional case has magnitude < 2^24.
  - inexact = guard|sticky.
- Undefined: truncate toward zero (C cast semantics); guard and sticky only drive inexact.

Decomposition:
- Shared package float_pkg holds:
  - constants FP_BIAS=127, FP_EXP_W=8, FP_MAN_W=23, INT_MAX, INT_MIN;
  - the state encoding localparams;
  - the NaN/Inf classification function.
- One natural sub-module: f2i_align, the combinational shifter producing magnitude, guard and sticky from {E,F}. The FSM, rounding and saturation stay in the top.

Test Plan:
- 32'h3F80_0000 (1.0) accepted at edge 0 -> output_z=32'h0000_0001, flags 000, output_z_stb high after edge 3.
- 32'hC2F6_E979 (-123.456) -> 32'hFFFF_FF85 (-123), inexact=1; 32'h8000_0000 (-0.0) -> 0, flags 000.
- 32'h4F00_0000 (2^31) -> 32'h7FFF_FFFF, overflow=1; 32'hCF00_0000 -> 32'h8000_0000, overflow=0; 32'h7FC0_0000 -> 32'h8000_0000, invalid=1; 32'hFF80_0000 -> 32'h8000_0000, overflow=1.
- Hold output_z_ack=0 for 10 cycles in DONE -> output_z, output_z_stb and flags stable, input_a_ack=0; ack=1 -> input_a_ack=1 next cycle.
- rst driven low while in ALIGN -> output_z_stb=0 and input_a_ack=1 immediately; no result emitted after release.
- 32'h4020_0000 (2.5) / 32'h4060_0000 (3.5): with ROUND_NEAREST_EN -> 2 / 4, inexact=1; without it -> 2 / 3, inexact=1.

Source files
------------

// File: rtl/float_pkg.sv
// float_pkg: shared IEEE-754 single constants, FSM state encoding and operand classification
// for the float_to_int converter.
package float_pkg;
    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UNPACK = 3'd1;
    localparam logic [2:0] ST_ALIGN  = 3'd2;
    localparam logic [2:0] ST_ROUND  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        UNPACK = ST_UNPACK,
        ALIGN  = ST_ALIGN,
        ROUND  = ST_ROUND,
        DONE   = ST_DONE
    } state_t;

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    function automatic cls_t classify(input logic [FP_EXP_W-1:0] e, input logic [FP_MAN_W-1:0] f);
        return (&e) ? ((|f) ? CLS_NAN : CLS_INF) : (e == '0) ? CLS_ZERO : CLS_NUM;
    endfunction
endpackage

// File: rtl/float_to_int_if.sv
// float_to_int_if: operand/result strobe-ack handshake plus status flags of the converter.
interface float_to_int_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_inexact;

    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb, flag_invalid, flag_overflow, flag_inexact
    );
    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb, flag_invalid, flag_overflow, flag_inexact
    );
endinterface

// File: rtl/f2i_align.sv
// f2i_align: combinational alignment of {1,F} by the unbiased exponent into an integer magnitude,
// plus the guard bit and sticky OR of everything shifted out.
module f2i_align
    import float_pkg::*;
(
    input  logic [FP_EXP_W-1:0] exp_i,
    input  logic [FP_MAN_W-1:0] frac_i,
    output logic [31:0]         mag_o,
    output logic                guard_o,
    output logic                sticky_o
);
    logic signed [8:0] e;
    logic [23:0] m;
    logic [4:0] rsh;
    logic [6:0] lsh;
    logic [47:0] ext;
    always_comb begin
        e = $signed({1'b0, exp_i}) - 9'(FP_BIAS);
        m = {1'b1, frac_i};
        rsh = 5'(9'd23 - e);
        lsh = 7'(e - 9'sd23);
        ext = {m, 24'b0} >> rsh;
        mag_o = '0;
        guard_o = 1'b0;
        sticky_o = 1'b0;
        if (exp_i == '0)
            sticky_o = |frac_i;
        else if (e >= 9'sd23)
            mag_o = {8'b0, m} << lsh;
        else if (e >= 9'sd0) begin
            mag_o = {8'b0, ext[47:24]};
            guard_o = ext[23];
            sticky_o = |ext[22:0];
        end else begin
            // e = -1 puts the hidden bit in the guard position; anything smaller is pure sticky
            guard_o = (e == -9'sd1);
            sticky_o = (e == -9'sd1) ? |frac_i : 1'b1;
        end
    end
endmodule

// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 single to signed int32 with strobe/ack handshake and a fixed 4-state pipeline walk.
// Define ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module float_to_int
    import float_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'h8000_0000,
    parameter logic [31:0] POS_SAT   = INT_MAX,
    parameter logic [31:0] NEG_SAT   = INT_MIN
) (
    input logic clk,
    input logic rst,
    float_to_int_if.slave bus
);
    state_t state_q, state_d;
    cls_t cls_q;
    logic signed [8:0] e_q;
    logic [31:0] a_q, mag_q, z_q, z_d, mag_w, rmag;
    logic guard_q, sticky_q, inv_q, ovf_q, inx_q;
    logic guard_w, sticky_w, round_up, sat, inv_d, ovf_d, inx_d;

    f2i_align u_align (
        .exp_i(a_q[30:23]), .frac_i(a_q[22:0]),
        .mag_o(mag_w), .guard_o(guard_w), .sticky_o(sticky_w)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.input_a_stb ? UNPACK : IDLE;
            UNPACK:  state_d = ALIGN;
            ALIGN:   state_d = ROUND;
            ROUND:   state_d = DONE;
            default: state_d = bus.output_z_ack ? IDLE : DONE;
        endcase
    end

`ifdef ROUND_NEAREST_EN
    assign round_up = guard_q & (sticky_q | mag_q[0]);
`else
    assign round_up = 1'b0;
`endif

    // -2^31 is the one e=31 value that fits; its magnitude negates onto itself
    always_comb begin
        rmag = mag_q + {31'b0, round_up};
        sat = (cls_q == CLS_INF) || (e_q >= 9'sd31 && a_q != 32'hCF00_0000);
        inv_d = (cls_q == CLS_NAN);
        ovf_d = !inv_d && sat;
        inx_d = !inv_d && !sat && (guard_q | sticky_q);
        z_d = inv_d ? NAN_VALUE : sat ? (a_q[31] ? NEG_SAT : POS_SAT) : a_q[31] ? -rmag : rmag;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            a_q <= '0;
            cls_q <= CLS_ZERO;
            e_q <= '0;
            mag_q <= '0;
            guard_q <= 1'b0;
            sticky_q <= 1'b0;
            z_q <= '0;
            inv_q <= 1'b0;
            ovf_q <= 1'b0;
            inx_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.input_a_stb) a_q <= bus.input_a;
            if (state_q == UNPACK) begin
                cls_q <= classify(a_q[30:23], a_q[22:0]);
                e_q <= $signed({1'b0, a_q[30:23]}) - 9'(FP_BIAS);
            end
            if (state_q == ALIGN) begin
                mag_q <= mag_w;
                guard_q <= guard_w;
                sticky_q <= sticky_w;
            end
            if (state_q == ROUND) begin
                z_q <= z_d;
                inv_q <= inv_d;
                ovf_q <= ovf_d;
                inx_q <= inx_d;
            end
        end

    assign bus.input_a_ack = (state_q == IDLE);
    assign bus.output_z_stb = (state_q == DONE);
    assign bus.output_z = z_q;
    assign bus.flag_invalid = inv_q;
    assign bus.flag_overflow = ovf_q;
    assign bus.flag_inexact = inx_q;
endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed vector table, handshake/reset corner sequences and random operands
// checked against an arithmetic reference model of the float-to-int conversion.
module tb_float_to_int;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    float_to_int_if bus();
    float_to_int dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [34:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {z, invalid, overflow, inexact} from the real value M * 2^(e-23)
    function automatic logic [34:0] model(input logic [31:0] a);
        logic s;
        int ex, e, sh;
        longint m, p, ip, rem, v;
        logic [31:0] sat;
        s = a[31];
        ex = int'(a[30:23]);
        sat = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (ex == 255) return (a[22:0] != 0) ? {32'h8000_0000, 3'b100} : {sat, 3'b010};
        m = (ex == 0) ? longint'(a[22:0]) : longint'({1'b1, a[22:0]});
        e = (ex == 0) ? -126 : ex - 127;
        if (e >= 40) return {sat, 3'b010};
        if (e >= 23) begin
            ip = m * (longint'(1) << (e - 23));
            rem = 0;
            p = 2;
        end else begin
            sh = (23 - e > 40) ? 40 : 23 - e;
            p = longint'(1) << sh;
            ip = m / p;
            rem = m % p;
        end
`ifdef ROUND_NEAREST_EN
        if (rem > p / 2 || (rem == p / 2 && ip % 2 == 1)) ip++;
`endif
        v = s ? -ip : ip;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) return {sat, 3'b010};
        return {v[31:0], 2'b00, rem != 0};
    endfunction

    task automatic send(input logic [31:0] a);
        int n = 0;
        while (!bus.input_a_ack && n < 20) begin
            @(posedge clk); #1; n++;
        end
        bus.input_a = a;
        bus.input_a_stb = 1'b1;
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        bus.input_a = $urandom;
    endtask

    task automatic wait_result(output logic [34:0] res);
        int n = 0;
        while (!bus.output_z_stb && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.output_z_stb) chk("result_timeout", 35'(bus.output_z_stb), 35'd1);
        res = {bus.output_z, bus.flag_invalid, bus.flag_overflow, bus.flag_inexact};
    endtask

    task automatic do_ack();
        bus.output_z_ack = 1'b1;
        @(posedge clk); #1;
        bus.output_z_ack = 1'b0;
    endtask

    task automatic run(input logic [31:0] a, output logic [34:0] res);
        send(a);
        wait_result(res);
        do_ack();
    endtask

    initial begin
        logic [34:0] res, first;
        logic [31:0] a;
        int seen;
        bus.input_a = '0;
        bus.input_a_stb = 1'b0;
        bus.output_z_ack = 1'b0;

        vecs.push_back('{32'h3F80_0000, {32'h0000_0001, 3'b000}});
        vecs.push_back('{32'hC2F6_E979, {32'hFFFF_FF85, 3'b001}});
        vecs.push_back('{32'h8000_0000, {32'h0000_0000, 3'b000}});
        vecs.push_back('{32'h4F00_0000, {32'h7FFF_FFFF, 3'b010}});
        vecs.push_back('{32'hCF00_0000, {32'h8000_0000, 3'b000}});
        vecs.push_back('{32'h7FC0_0000, {32'h8000_0000, 3'b100}});
        vecs.push_back('{32'hFF80_0000, {32'h8000_0000, 3'b010}});
        vecs.push_back('{32'h7F80_0000, {32'h7FFF_FFFF, 3'b010}});
        vecs.push_back('{32'h3F00_0000, {32'h0000_0000, 3'b001}});
        vecs.push_back('{32'h0000_0001, {32'h0000_0000, 3'b001}});
        vecs.push_back('{32'h4020_0000, {32'h0000_0002, 3'b001}});
`ifdef ROUND_NEAREST_EN
        vecs.push_back('{32'h4060_0000, {32'h0000_0004, 3'b001}});
        vecs.push_back('{32'h3F40_0000, {32'h0000_0001, 3'b001}});
        vecs.push_back('{32'hBFC0_0000, {32'hFFFF_FFFE, 3'b001}});
`else
        vecs.push_back('{32'h4060_0000, {32'h0000_0003, 3'b001}});
        vecs.push_back('{32'h3F40_0000, {32'h0000_0000, 3'b001}});
        vecs.push_back('{32'hBFC0_0000, {32'hFFFF_FFFF, 3'b001}});
`endif

        #1;
        chk("reset_state", {bus.output_z, bus.flag_invalid, bus.flag_overflow, bus.flag_inexact},
            {32'h0, 3'b000});
        chk("reset_handshake", 35'({bus.input_a_ack, bus.output_z_stb}), 35'b10);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // latency: stb low after edges 1 and 2, high after edge 3
        send(32'h3F80_0000);
        chk("lat_edge0", 35'({bus.input_a_ack, bus.output_z_stb}), 35'b00);
        @(posedge clk); #1;
        chk("lat_edge1", 35'(bus.output_z_stb), 35'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 35'(bus.output_z_stb), 35'd0);
        @(posedge clk); #1;
        chk("lat_edge3", {bus.output_z, bus.flag_invalid, bus.flag_overflow, bus.flag_inexact, bus.output_z_stb} >> 1,
            {32'h1, 3'b000});
        chk("lat_stb", 35'(bus.output_z_stb), 35'd1);
        do_ack();

        foreach (vecs[i]) begin
            run(vecs[i].a, res);
            chk($sformatf("vec_%08h_z", vecs[i].a), 35'(res[34:3]), 35'(vecs[i].exp[34:3]));
            chk($sformatf("vec_%08h_flags", vecs[i].a), 35'(res[2:0]), 35'(vecs[i].exp[2:0]));
        end

        // stall in DONE for 10 cycles
        send(32'hC2F6_E979);
        wait_result(first);
        chk("stall_first", first, {32'hFFFF_FF85, 3'b001});
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("stall_hold", {bus.output_z, bus.flag_invalid, bus.flag_overflow, bus.flag_inexact}, first);
            chk("stall_handshake", 35'({bus.output_z_stb, bus.input_a_ack}), 35'b10);
        end
        do_ack();
        chk("stall_release", 35'({bus.output_z_stb, bus.input_a_ack}), 35'b01);

        // reset while in ALIGN drops the operation
        send(32'h42F6_0000);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("async_reset", 35'({bus.output_z_stb, bus.input_a_ack}), 35'b01);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.output_z_stb || !bus.input_a_ack) seen++;
        end
        chk("no_result_after_reset", 35'(seen), 35'd0);

        for (int k = 0; k < 300; k++) begin
            int r;
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r == 0) a[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            else a[30:23] = 8'(110 + $urandom_range(0, 50));
            if (r % 3 == 0) a[22:0] = a[22:0] & 23'h7F_0000;
            if (r == 9) a[22:0] = '0;
            run(a, res);
            chk($sformatf("rand_%08h", a), res, model(a));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
